// File: rtl/free_list_bank.sv
// free_list_bank: one bank of the physical-register free list.
// Circular FIFO of free PR rows (PR = row*PRF_BANK_COUNT + BANK_INDEX) with
// occupancy count, low/high watermark flags and a sticky overflow flag.
// Optional feature macro: FREE_LIST_BANK_BYPASS_EN, which forwards an enqueue
// straight to the dequeue port when the list is empty.
module free_list_bank #(
    parameter int unsigned BANK_INDEX      = 0,
    parameter int unsigned LENGTH          = 32,
    parameter int unsigned LOWER_THRESHOLD = 8,
    parameter int unsigned UPPER_THRESHOLD = 24,
    localparam int unsigned ROW_W          = $clog2(LENGTH),
    localparam int unsigned CNT_W          = ROW_W + 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             enq_valid,
    input  logic [ROW_W-1:0] enq_PR_row,
    output logic             deq_valid,
    input  logic             deq_ready,
    output logic [ROW_W-1:0] deq_PR_row,
    output logic [CNT_W-1:0] count,
    output logic             below_lower,
    output logic             above_upper,
    output logic             overflow_err
);

    // Architectural registers occupy the first AR_COUNT PRs, i.e. the first
    // AR_COUNT/PRF_BANK_COUNT rows of every bank are never free after reset.
    localparam int unsigned PRF_BANK_COUNT = 4;
    localparam int unsigned AR_COUNT       = 32;
    localparam int unsigned RESERVED_ROWS  = AR_COUNT / PRF_BANK_COUNT;
    localparam int unsigned RST_FREE       = LENGTH - RESERVED_ROWS;

    localparam logic [CNT_W-1:0] CNT_RST  = CNT_W'(RST_FREE);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LENGTH);
    localparam logic [ROW_W-1:0] TAIL_RST = ROW_W'(RST_FREE % LENGTH);
    localparam logic [ROW_W-1:0] PTR_LAST = ROW_W'(LENGTH - 1);
    localparam logic [CNT_W-1:0] LOW_WM   = CNT_W'(LOWER_THRESHOLD);
    localparam logic [CNT_W-1:0] HIGH_WM  = CNT_W'(UPPER_THRESHOLD);

    logic [ROW_W-1:0] entry_q [LENGTH];
    logic [ROW_W-1:0] head_q;
    logic [ROW_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;
    logic             ovf_q;

    logic [ROW_W-1:0] head_d;
    logic [ROW_W-1:0] tail_d;
    logic [CNT_W-1:0] count_d;
    logic             ovf_d;

    logic             empty_c;
    logic             full_c;
    logic             bypass_c;
    logic             bypass_take_c;
    logic             fifo_deq_c;
    logic             enq_acc_c;
    logic             enq_drop_c;

    // Pointer advance with explicit wrap so non-power-of-two depths work.
    function automatic logic [ROW_W-1:0] ptr_inc(input logic [ROW_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + ROW_W'(1);
    endfunction

    assign empty_c = (count_q == '0);
    assign full_c  = (count_q == CNT_FULL);

`ifdef FREE_LIST_BANK_BYPASS_EN
    // Empty list: the freed row is offered to rename in the same cycle.
    assign bypass_c = empty_c && enq_valid;
`else
    assign bypass_c = 1'b0;
`endif

    // Handshake decode: which of dequeue / enqueue / overflow happen this cycle.
    always_comb begin
        fifo_deq_c    = 1'b0;
        bypass_take_c = 1'b0;
        enq_acc_c     = 1'b0;
        enq_drop_c    = 1'b0;
        // Dequeue from storage only when a stored row is presented.
        fifo_deq_c    = deq_ready && !empty_c;
        // A bypassed row consumed by rename never touches the storage.
        bypass_take_c = bypass_c && deq_ready;
        // A full list still accepts an enqueue if a slot frees the same cycle.
        enq_acc_c     = enq_valid && (!full_c || fifo_deq_c) && !bypass_take_c;
        enq_drop_c    = enq_valid && full_c && !fifo_deq_c;
    end

    // Next-state computation for pointers, occupancy and the sticky error.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (fifo_deq_c) begin
            head_d = ptr_inc(head_q);
        end
        if (enq_acc_c) begin
            tail_d = ptr_inc(tail_q);
        end
        count_d = count_q + CNT_W'(enq_acc_c) - CNT_W'(fifo_deq_c);
        if (enq_drop_c) begin
            ovf_d = 1'b1;
        end
    end

    // Control state registers; reset restores the post-boot free list.
    always_ff @(posedge CLK) begin
        if (RST) begin
            head_q  <= '0;
            tail_q  <= TAIL_RST;
            count_q <= CNT_RST;
            ovf_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Entry storage: reset preloads rows RESERVED_ROWS..LENGTH-1 in order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int unsigned i = 0; i < LENGTH; i++) begin
                entry_q[i] <= (i < RST_FREE) ? ROW_W'(i + RESERVED_ROWS) : '0;
            end
        end else if (enq_acc_c) begin
            entry_q[tail_q] <= enq_PR_row;
        end
    end

    // Structural invariants: legal bank index, occupancy never past depth.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            assert ((BANK_INDEX < PRF_BANK_COUNT) && (count_q <= CNT_FULL));
        end
    end

`ifdef FREE_LIST_BANK_BYPASS_EN
    // Dequeue port: stored head, or the incoming row when bypassing.
    assign deq_valid  = !empty_c || bypass_c;
    assign deq_PR_row = bypass_c ? enq_PR_row : entry_q[head_q];
`else
    // Dequeue port driven purely from registered state.
    assign deq_valid  = !empty_c;
    assign deq_PR_row = entry_q[head_q];
`endif

    assign count        = count_q;
    assign overflow_err = ovf_q;
    assign below_lower  = (count_q < LOW_WM);
    assign above_upper  = (count_q > HIGH_WM);

endmodule

// File: tb/tb_free_list_bank.sv
// Testbench for free_list_bank: queue-based reference model checked every
// cycle on the falling edge, plus directed scenarios with literal expectations.
module tb_free_list_bank;

`ifdef FREE_LIST_BANK_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       CLK;
    logic       RST;
    logic       enq_valid;
    logic [4:0] enq_PR_row;
    logic       deq_valid;
    logic       deq_ready;
    logic [4:0] deq_PR_row;
    logic [5:0] count;
    logic       below_lower;
    logic       above_upper;
    logic       overflow_err;

    int n_total = 0;
    int n_pass  = 0;
    bit chk_en  = 1'b0;

    int mq[$];
    bit movf;

    free_list_bank dut (
        .CLK          (CLK),
        .RST          (RST),
        .enq_valid    (enq_valid),
        .enq_PR_row   (enq_PR_row),
        .deq_valid    (deq_valid),
        .deq_ready    (deq_ready),
        .deq_PR_row   (deq_PR_row),
        .count        (count),
        .below_lower  (below_lower),
        .above_upper  (above_upper),
        .overflow_err (overflow_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Reference model: a plain queue of free rows updated at each rising edge.
    always @(posedge CLK) begin
        if (RST) begin
            mq.delete();
            for (int i = 8; i < 32; i++) mq.push_back(i);
            movf = 1'b0;
        end else if (mq.size() == 0) begin
            if (enq_valid && !(BYP && deq_ready)) mq.push_back(int'(enq_PR_row));
        end else if (enq_valid && mq.size() == 32 && !deq_ready) begin
            movf = 1'b1;
        end else begin
            if (deq_ready) void'(mq.pop_front());
            if (enq_valid) mq.push_back(int'(enq_PR_row));
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge CLK) begin
        if (chk_en) begin
            logic exp_v;
            exp_v = (mq.size() != 0) || (BYP && enq_valid);
            chk("m_count", 32'(count), 32'(mq.size()));
            chk("m_deq_valid", 32'(deq_valid), 32'(exp_v));
            if (exp_v)
                chk("m_deq_row", 32'(deq_PR_row),
                    (mq.size() != 0) ? 32'(mq[0]) : 32'(enq_PR_row));
            chk("m_below", 32'(below_lower), 32'(mq.size() < 8));
            chk("m_above", 32'(above_upper), 32'(mq.size() > 24));
            chk("m_ovf", 32'(overflow_err), 32'(movf));
        end
    end

    // One clock of stimulus, then inputs return to idle.
    task automatic step(input logic r, input logic e, input logic [4:0] row, input logic d);
        RST = r; enq_valid = e; enq_PR_row = row; deq_ready = d;
        @(posedge CLK);
        #1;
        RST = 1'b0; enq_valid = 1'b0; enq_PR_row = '0; deq_ready = 1'b0;
    endtask

    initial begin
        RST = 1'b1; enq_valid = 1'b0; enq_PR_row = '0; deq_ready = 1'b0;

        // Reset state and in-order drain of the preloaded rows.
        step(1'b1, 1'b0, 5'd0, 1'b0);
        chk_en = 1'b1;
        chk("rst_count", 32'(count), 32'd24);
        chk("rst_row", 32'(deq_PR_row), 32'd8);
        chk("rst_valid", 32'(deq_valid), 32'd1);
        chk("rst_below", 32'(below_lower), 32'd0);
        chk("rst_above", 32'(above_upper), 32'd0);
        chk("rst_ovf", 32'(overflow_err), 32'd0);
        for (int i = 0; i < 24; i++) begin
            chk("drain_row", 32'(deq_PR_row), 32'(8 + i));
            step(1'b0, 1'b0, 5'd0, 1'b1);
        end
        chk("drain_valid", 32'(deq_valid), 32'd0);
        chk("drain_below", 32'(below_lower), 32'd1);
        chk("drain_count", 32'(count), 32'd0);
        // deq_ready while empty is ignored
        step(1'b0, 1'b0, 5'd0, 1'b1);
        chk("empty_ready_count", 32'(count), 32'd0);

        // Wrap-around: fill to 32 then drain all 32.
        step(1'b1, 1'b0, 5'd0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 5'(i), 1'b0);
        chk("wrap_full_count", 32'(count), 32'd32);
        chk("wrap_full_above", 32'(above_upper), 32'd1);
        for (int i = 0; i < 32; i++) begin
            chk("wrap_row", 32'(deq_PR_row), (i < 24) ? 32'(i + 8) : 32'(i - 24));
            step(1'b0, 1'b0, 5'd0, 1'b1);
        end
        chk("wrap_end_count", 32'(count), 32'd0);
        // pointers back at slot 0: a fresh enqueue comes straight back out
        step(1'b0, 1'b1, 5'd3, 1'b0);
        chk("wrap_reuse_row", 32'(deq_PR_row), 32'd3);

        // Overflow with and without a same-cycle dequeue.
        step(1'b1, 1'b0, 5'd0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 5'(i), 1'b0);
        step(1'b0, 1'b1, 5'd5, 1'b0);
        chk("ovf_flag", 32'(overflow_err), 32'd1);
        chk("ovf_count", 32'(count), 32'd32);
        chk("ovf_head", 32'(deq_PR_row), 32'd8);
        step(1'b0, 1'b1, 5'd5, 1'b1);
        chk("full_both_count", 32'(count), 32'd32);
        chk("full_both_head", 32'(deq_PR_row), 32'd9);
        chk("ovf_sticky", 32'(overflow_err), 32'd1);

        // Reset wins over a same-cycle enqueue and dequeue.
        step(1'b1, 1'b1, 5'd5, 1'b1);
        chk("rmid_count", 32'(count), 32'd24);
        chk("rmid_row", 32'(deq_PR_row), 32'd8);
        chk("rmid_valid", 32'(deq_valid), 32'd1);
        chk("rmid_below", 32'(below_lower), 32'd0);
        chk("rmid_above", 32'(above_upper), 32'd0);
        chk("rmid_ovf", 32'(overflow_err), 32'd0);

        // Watermarks around 24/25 and 8/7.
        step(1'b0, 1'b1, 5'd1, 1'b0);
        chk("wm_25_above", 32'(above_upper), 32'd1);
        chk("wm_25_count", 32'(count), 32'd25);
        step(1'b0, 1'b0, 5'd0, 1'b1);
        chk("wm_24_above", 32'(above_upper), 32'd0);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 5'd0, 1'b1);
        chk("wm_8_count", 32'(count), 32'd8);
        chk("wm_8_below", 32'(below_lower), 32'd0);
        step(1'b0, 1'b0, 5'd0, 1'b1);
        chk("wm_7_below", 32'(below_lower), 32'd1);

        // Simultaneous enqueue/dequeue mid-range keeps count.
        step(1'b0, 1'b1, 5'd20, 1'b1);
        chk("mid_both_count", 32'(count), 32'd7);

        // Empty-list enqueue with rename ready.
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 5'd0, 1'b1);
        chk("pre_empty_count", 32'(count), 32'd0);
        enq_valid = 1'b1; enq_PR_row = 5'd17; deq_ready = 1'b1;
        #1;
        chk("emp_same_valid", 32'(deq_valid), BYP ? 32'd1 : 32'd0);
        if (BYP) chk("emp_same_row", 32'(deq_PR_row), 32'd17);
        @(posedge CLK);
        #1;
        enq_valid = 1'b0; enq_PR_row = '0; deq_ready = 1'b0;
        chk("emp_next_count", 32'(count), BYP ? 32'd0 : 32'd1);
        chk("emp_next_valid", 32'(deq_valid), BYP ? 32'd0 : 32'd1);
        if (!BYP) chk("emp_next_row", 32'(deq_PR_row), 32'd17);
        step(1'b0, 1'b0, 5'd0, 1'b0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
